fir_coeff_loader: RTL and testbench
===================================

# fir_coeff_loader

Coefficient configuration controller for `fir_serial`. Accepts filter coefficients one at a time over a valid/ready stream into a shadow bank. On a sample-boundary strobe, it swaps the shadow bank atomically into the active bank. The active bank drives `fir_serial.i_coeffs` directly, so the filter never sees a partially updated coefficient set.

## Interface
- `NB_COEFFS`, 8, coefficient width in bits (signed, two's complement)
- `N_COEFFS`, 8, number of filter taps; must be ≥ 2
- `i_clock`  in  1  single clock; all state changes on the rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_start`  in  1  begin a load sequence; sampled only in IDLE
- `i_abort`  in  1  cancel the load in progress; shadow bank is discarded
- `i_coeff`  in  NB_COEFFS  coefficient word
- `i_coeff_valid`  in  1  `i_coeff` is valid
- `o_coeff_ready`  out  1  loader accepts a coefficient this cycle
- `i_sample_tick`  in  1  one-cycle strobe marking a filter sample boundary
- `o_coeffs`  out  NB_COEFFS*N_COEFFS  active bank; tap k occupies `[(k+1)*NB_COEFFS-1 -: NB_COEFFS]`
- `o_busy`  out  1  high in LOAD or WAIT_SWAP
- `o_done`  out  1  one-cycle pulse: new active bank is visible
- `o_start_err`  out  1  one-cycle pulse: `i_start` arrived while busy

## Operation
- N_LOAD is the number of words per load: N_COEFFS by default, or (N_COEFFS+1)/2 with the symmetric option (see Configuration).
- The FSM has states IDLE, LOAD and WAIT_SWAP. The word counter `cnt` is $clog2(N_LOAD) bits wide.
- IDLE:
  - `o_coeff_ready` = 0.
  - `i_start` → LOAD, `cnt` ← 0.
  - `i_abort` has no effect.
- LOAD:
  - `o_coeff_ready` = 1.
  - A word is accepted when `i_coeff_valid` && `o_coeff_ready`.
  - On accept: shadow[`cnt`] ← `i_coeff`, `cnt`++.
  - Accepting word N_LOAD-1 → WAIT_SWAP.
  - Cycles with `i_coeff_valid` low are stalls; nothing changes.
- WAIT_SWAP:
  - `o_coeff_ready` = 0.
  - On `i_sample_tick`: `o_coeffs` ← shadow, `o_done` ← 1, → IDLE.
- `i_abort` in LOAD or WAIT_SWAP → IDLE. The shadow bank contents are don't-care, `o_coeffs` is unchanged and `o_done` is not pulsed.
- Precedence in a single cycle: abort over a coefficient accept, and abort over a swap.
- `i_start` while busy is ignored and pulses `o_start_err` in the following cycle. This includes `i_start` coinciding with a swap tick.
- `o_coeffs` changes only on a swap edge. All taps change on the same edge.
- The shadow bank is not reset. Word k has been written before any swap, so reset values are never exposed.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0
  - `o_coeffs` = 0 (all taps zero; filter output is zero)
  - `o_coeff_ready` = 0, `o_busy` = 0, `o_done` = 0, `o_start_err` = 0
- `o_coeff_ready` and `o_busy` are decoded directly from state.
- The first `o_coeff_ready` = 1 is in the cycle after the `i_start` edge.
- Swap edge E is the edge where `i_sample_tick` = 1 in WAIT_SWAP.
  - New `o_coeffs` and `o_done` = 1 are both visible in the cycle after E.
  - `o_done` drops after one cycle.
- A `i_sample_tick` arriving while in IDLE or LOAD is ignored and not remembered.
- `i_start` is accepted in the `o_done` cycle, since state is already IDLE.
- Minimum start-to-done latency is N_LOAD + 2 cycles: 1 cycle to enter LOAD, N_LOAD accepts, 1 swap edge with the tick present immediately.
- `i_reset` asserted mid-load or in WAIT_SWAP immediately forces all reset values. That includes `o_coeffs` = 0.

## Configuration
- `FIR_COEFF_SYMMETRIC_EN`
  - **Defined:** N_LOAD = (N_COEFFS+1)/2. Accepted word k is written to taps k and N_COEFFS-1-k. For odd N_COEFFS, the middle tap is written once.
  - **Undefined:** N_LOAD = N_COEFFS, and word k is written to tap k only.
  - The interface is identical in both builds.

## Test plan
- **Full load (default build):** after reset, `i_start`, then stream -7, -14, 20, 56, 56, 20, -14, -7 with `i_coeff_valid` held high, then `i_sample_tick`. Required: tap0 = -7 … tap7 = -7, `o_done` pulses exactly once, and `o_coeffs` equals 0 until that cycle.
- **Backpressure and tick timing:**
  - Same load, with `i_coeff_valid` low on alternate cycles: only 8 words are accepted.
  - `i_sample_tick` during LOAD is ignored.
  - The swap happens only on the first tick in WAIT_SWAP, 5 cycles later.
- **Abort:**
  - Load all 8, then `i_abort` and `i_sample_tick` in the same cycle. Required: IDLE, previous `o_coeffs` retained, no `o_done`.
  - Then start and load 1..8 cleanly: taps become 1..8.
- **Start error:** `i_start` during LOAD (after 3 words). Required: `o_start_err` pulses for 1 cycle, `cnt` continues, and the load completes normally.
- **Reset mid-operation:** assert `i_reset` in WAIT_SWAP with a valid active bank loaded. Required: `o_coeffs` = 0, `o_busy` = 0 immediately; a subsequent full load works.
- **Symmetric build (`FIR_COEFF_SYMMETRIC_EN`, N_COEFFS = 8):** load -7, -14, 20, 56. Required: `o_coeffs` = {-7, -14, 20, 56, 56, 20, -14, -7}, and `o_coeff_ready` drops after the 4th word.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Double-buffered coefficient loader for fir_serial: stream words into a shadow bank, swap to the active bank on a sample tick.
// Define FIR_COEFF_SYMMETRIC_EN to load (N_COEFFS+1)/2 words, each mirrored to taps k and N_COEFFS-1-k.
module fir_coeff_loader #(
  parameter int NB_COEFFS = 8,
  parameter int N_COEFFS  = 8
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [NB_COEFFS-1:0]          i_coeff,
  input  logic                          i_coeff_valid,
  output logic                          o_coeff_ready,
  input  logic                          i_sample_tick,
  output logic [NB_COEFFS*N_COEFFS-1:0] o_coeffs,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_start_err
);

`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam int N_LOAD = (N_COEFFS + 1) / 2;
  localparam bit SYM    = 1'b1;
`else
  localparam int N_LOAD = N_COEFFS;
  localparam bit SYM    = 1'b0;
`endif
  // A one-word load still needs a 1-bit counter.
  localparam int CNT_W = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [NB_COEFFS*N_COEFFS-1:0]   shadow;
  logic                            accept;
  logic                            last_word;

  assign o_coeff_ready = (state == LOAD);
  assign o_busy        = (state != IDLE);
  assign accept        = o_coeff_ready && i_coeff_valid && !i_abort;
  assign last_word     = (cnt == CNT_W'(N_LOAD - 1));

  // Every tap is written before any swap can happen, so no reset is needed.
  always_ff @(posedge i_clock) begin
    if (accept) begin
      for (int k = 0; k < N_COEFFS; k++) begin
        if (k == int'(cnt) || (SYM && k == N_COEFFS - 1 - int'(cnt))) begin
          shadow[k*NB_COEFFS +: NB_COEFFS] <= i_coeff;
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      o_coeffs    <= '0;
      o_done      <= 1'b0;
      o_start_err <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_start_err <= i_start && (state != IDLE);
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (i_abort) begin
            state <= IDLE;
          end else if (i_coeff_valid) begin
            cnt <= cnt + 1'b1;
            if (last_word) state <= WAIT_SWAP;
          end
        end
        WAIT_SWAP: begin
          if (i_abort) begin
            state <= IDLE;
          end else if (i_sample_tick) begin
            o_coeffs <= shadow;
            o_done   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader; expected banks come from a tap-placement model of the load rules.
module tb_fir_coeff_loader;
  localparam int NB = 8;
  localparam int N  = 8;
  localparam int W  = NB * N;
`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam int N_LOAD = (N + 1) / 2;
  localparam bit SYM    = 1'b1;
`else
  localparam int N_LOAD = N;
  localparam bit SYM    = 1'b0;
`endif

  typedef logic [NB-1:0] bank_t [N];

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [NB-1:0] i_coeff = '0;
  logic          i_coeff_valid = 1'b0;
  logic          o_coeff_ready;
  logic          i_sample_tick = 1'b0;
  logic [W-1:0]  o_coeffs;
  logic          o_busy;
  logic          o_done;
  logic          o_start_err;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] exp_active = '0;

  fir_coeff_loader #(.NB_COEFFS(NB), .N_COEFFS(N)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_coeff(i_coeff), .i_coeff_valid(i_coeff_valid), .o_coeff_ready(o_coeff_ready),
    .i_sample_tick(i_sample_tick), .o_coeffs(o_coeffs), .o_busy(o_busy),
    .o_done(o_done), .o_start_err(o_start_err)
  );

  always #5 i_clock = ~i_clock;

  // Word k lands on tap k, and on its mirror tap when symmetric.
  function automatic logic [W-1:0] model_bank(input bank_t w);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_LOAD; k++) begin
      r[k*NB +: NB] = w[k];
      if (SYM) r[(N-1-k)*NB +: NB] = w[k];
    end
    return r;
  endfunction

  function automatic bank_t rand_bank();
    bank_t w;
    for (int k = 0; k < N; k++) w[k] = NB'($urandom());
    return w;
  endfunction

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic start_load();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // mode 0: valid always high, 1: valid on alternate cycles, 2: random stalls plus stray ticks
  task automatic send_words(input bank_t w, input int mode, output int accepted);
    int  cycles;
    logic acc_now;
    accepted = 0;
    cycles   = 0;
    while (accepted < N_LOAD && cycles < 200) begin
      case (mode)
        0:       i_coeff_valid = 1'b1;
        1:       i_coeff_valid = cycles[0];
        default: i_coeff_valid = ($urandom_range(3) != 0);
      endcase
      i_sample_tick = (mode == 2) && ($urandom_range(3) == 0);
      i_coeff = w[accepted];
      acc_now = i_coeff_valid && o_coeff_ready;
      step();
      cycles++;
      if (acc_now) accepted++;
    end
    i_coeff_valid = 1'b0;
    i_sample_tick = 1'b0;
  endtask

  task automatic swap();
    i_sample_tick = 1'b1;
    step();
    i_sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    #12;
    tests++; if (o_coeffs !== '0)   begin fails++; $display("FAIL reset_coeffs: got %h want 0", o_coeffs); end
    tests++; if (o_coeff_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", o_coeff_ready); end
    tests++; if (o_busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    tests++; if (o_done !== 1'b0)   begin fails++; $display("FAIL reset_done: got %b want 0", o_done); end
    tests++; if (o_start_err !== 1'b0) begin fails++; $display("FAIL reset_start_err: got %b want 0", o_start_err); end
    step();
    i_reset = 1'b0;
    exp_active = '0;
    step();
  endtask

  task automatic test_full_load();
    bank_t w;
    logic [W-1:0] exp;
    int lat, dones, changed;
    w = '{8'hF9, 8'hF2, 8'h14, 8'h38, 8'h38, 8'h14, 8'hF2, 8'hF9};
    exp = model_bank(w);
    dones = 0; changed = 0;
    start_load();
    lat = 1;
    tests++; if (o_coeff_ready !== 1'b1) begin fails++; $display("FAIL full_first_ready: got %b want 1", o_coeff_ready); end
    tests++; if (o_start_err !== 1'b0) begin fails++; $display("FAIL full_idle_start_err: got %b want 0", o_start_err); end
    for (int i = 0; i < N_LOAD; i++) begin
      i_coeff_valid = 1'b1;
      i_coeff = w[i];
      step();
      lat++;
      if (o_coeffs !== exp_active) changed++;
      if (o_done) dones++;
    end
    i_coeff_valid = 1'b0;
    tests++; if (o_coeff_ready !== 1'b0) begin fails++; $display("FAIL full_ready_drop: got %b want 0", o_coeff_ready); end
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL full_wait_busy: got %b want 1", o_busy); end
    tests++; if (changed !== 0) begin fails++; $display("FAIL full_early_change: got %0d cycles changed want 0", changed); end
    swap();
    lat++;
    if (o_done) dones++;
    tests++; if (o_coeffs !== exp) begin fails++; $display("FAIL full_coeffs: got %h want %h", o_coeffs, exp); end
    tests++; if (o_done !== 1'b1) begin fails++; $display("FAIL full_done: got %b want 1", o_done); end
    tests++; if (lat !== N_LOAD + 2) begin fails++; $display("FAIL full_latency: got %0d want %0d", lat, N_LOAD + 2); end
    exp_active = exp;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_done) dones++;
    end
    tests++; if (dones !== 1) begin fails++; $display("FAIL full_done_count: got %0d want 1", dones); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL full_idle_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_backpressure();
    bank_t w;
    logic [W-1:0] exp;
    int accepted, cycles;
    logic acc_now;
    w = rand_bank();
    exp = model_bank(w);
    accepted = 0; cycles = 0;
    start_load();
    while (accepted < N_LOAD && cycles < 100) begin
      i_coeff_valid = cycles[0];
      i_sample_tick = (cycles == 2);
      i_coeff = w[accepted];
      acc_now = i_coeff_valid && o_coeff_ready;
      step();
      cycles++;
      if (acc_now) accepted++;
    end
    i_coeff_valid = 1'b0;
    i_sample_tick = 1'b0;
    tests++; if (accepted !== N_LOAD || cycles !== 2 * N_LOAD) begin fails++; $display("FAIL bp_accepts: got %0d words in %0d cycles want %0d in %0d", accepted, cycles, N_LOAD, 2 * N_LOAD); end
    tests++; if (o_coeff_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_drop: got %b want 0", o_coeff_ready); end
    for (int i = 0; i < 4; i++) step();
    tests++; if (o_coeffs !== exp_active || o_done !== 1'b0) begin fails++; $display("FAIL bp_stray_tick: got %h done %b want %h done 0", o_coeffs, o_done, exp_active); end
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL bp_wait_busy: got %b want 1", o_busy); end
    swap();
    tests++; if (o_coeffs !== exp || o_done !== 1'b1) begin fails++; $display("FAIL bp_swap: got %h done %b want %h done 1", o_coeffs, o_done, exp); end
    exp_active = exp;
    step();
  endtask

  task automatic test_abort();
    bank_t w;
    logic [W-1:0] exp;
    int accepted;
    w = rand_bank();
    start_load();
    send_words(w, 0, accepted);
    i_abort = 1'b1;
    i_sample_tick = 1'b1;
    step();
    i_abort = 1'b0;
    i_sample_tick = 1'b0;
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    tests++; if (o_coeffs !== exp_active || o_done !== 1'b0) begin fails++; $display("FAIL abort_swap: got %h done %b want %h done 0", o_coeffs, o_done, exp_active); end
    step();
    tests++; if (o_done !== 1'b0) begin fails++; $display("FAIL abort_late_done: got %b want 0", o_done); end
    start_load();
    i_coeff_valid = 1'b1;
    i_coeff = 8'h55;
    step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    i_coeff_valid = 1'b0;
    tests++; if (o_busy !== 1'b0 || o_coeff_ready !== 1'b0) begin fails++; $display("FAIL abort_load: got busy %b ready %b want 0 0", o_busy, o_coeff_ready); end
    for (int k = 0; k < N; k++) w[k] = NB'(k + 1);
    exp = model_bank(w);
    start_load();
    send_words(w, 0, accepted);
    swap();
    tests++; if (o_coeffs !== exp || o_done !== 1'b1) begin fails++; $display("FAIL abort_reload: got %h done %b want %h done 1", o_coeffs, o_done, exp); end
    exp_active = exp;
    step();
  endtask

  task automatic test_start_err();
    bank_t w;
    logic [W-1:0] exp;
    int errs;
    w = rand_bank();
    exp = model_bank(w);
    errs = 0;
    start_load();
    for (int i = 0; i < N_LOAD; i++) begin
      i_coeff_valid = 1'b1;
      i_coeff = w[i];
      i_start = (i == 3);
      step();
      if (o_start_err) errs++;
    end
    i_start = 1'b0;
    i_coeff_valid = 1'b0;
    tests++; if (errs !== 1) begin fails++; $display("FAIL serr_pulse: got %0d pulses want 1", errs); end
    tests++; if (o_busy !== 1'b1 || o_coeff_ready !== 1'b0) begin fails++; $display("FAIL serr_wait: got busy %b ready %b want 1 0", o_busy, o_coeff_ready); end
    i_start = 1'b1;
    swap();
    i_start = 1'b0;
    tests++; if (o_coeffs !== exp) begin fails++; $display("FAIL serr_coeffs: got %h want %h", o_coeffs, exp); end
    tests++; if (o_start_err !== 1'b1 || o_busy !== 1'b0) begin fails++; $display("FAIL serr_on_swap: got err %b busy %b want 1 0", o_start_err, o_busy); end
    exp_active = exp;
    step();
    tests++; if (o_start_err !== 1'b0) begin fails++; $display("FAIL serr_drop: got %b want 0", o_start_err); end
  endtask

  task automatic test_reset_mid();
    bank_t w;
    logic [W-1:0] exp;
    int accepted;
    w = rand_bank();
    start_load();
    send_words(w, 0, accepted);
    #2 i_reset = 1'b1;
    #1;
    tests++; if (o_coeffs !== '0) begin fails++; $display("FAIL rst_mid_coeffs: got %h want 0", o_coeffs); end
    tests++; if (o_busy !== 1'b0 || o_coeff_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got busy %b ready %b want 0 0", o_busy, o_coeff_ready); end
    step();
    i_reset = 1'b0;
    exp_active = '0;
    step();
    w = rand_bank();
    exp = model_bank(w);
    start_load();
    send_words(w, 2, accepted);
    swap();
    tests++; if (o_coeffs !== exp || o_done !== 1'b1) begin fails++; $display("FAIL rst_mid_reload: got %h done %b want %h done 1", o_coeffs, o_done, exp); end
    exp_active = exp;
    step();
  endtask

  task automatic test_random();
    bank_t w;
    logic [W-1:0] exp;
    int accepted, bad;
    bad = 0;
    for (int it = 0; it < 20; it++) begin
      w = rand_bank();
      exp = model_bank(w);
      start_load();
      send_words(w, 2, accepted);
      for (int d = $urandom_range(3); d > 0; d--) step();
      if (o_busy !== 1'b1 || o_coeffs !== exp_active) bad++;
      swap();
      if (o_coeffs !== exp || o_done !== 1'b1 || accepted !== N_LOAD) bad++;
      exp_active = exp;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL random_loads: got %0d bad iterations want 0", bad); end
    step();
  endtask

  task automatic test_back_to_back();
    bank_t w;
    logic [W-1:0] exp;
    int accepted;
    w = rand_bank();
    exp = model_bank(w);
    start_load();
    send_words(w, 0, accepted);
    swap();
    exp_active = exp;
    tests++; if (o_done !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b want 1", o_done); end
    start_load();
    tests++; if (o_coeff_ready !== 1'b1 || o_start_err !== 1'b0) begin fails++; $display("FAIL b2b_restart: got ready %b err %b want 1 0", o_coeff_ready, o_start_err); end
    w = rand_bank();
    exp = model_bank(w);
    send_words(w, 1, accepted);
    swap();
    tests++; if (o_coeffs !== exp) begin fails++; $display("FAIL b2b_coeffs: got %h want %h", o_coeffs, exp); end
    exp_active = exp;
    step();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_abort();
    test_start_err();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
